// File: rtl/pipe_stage_skid_reg.sv
// Purpose : parametrised pipeline stage register carrying LANES {pc, instr, pc+4} slots per beat.
// Latency : 1 cycle from accept to valid_o; 1 beat/cycle sustained while ready_i is held high.
// Backpr. : a 2-entry skid (main + skid) keeps ready_o a pure decode of the state register.
//
// Ports   : clk_i/rst_i (sync, active-high), flush_i drops held and incoming beats.
//           upstream   valid_i/ready_o, lane_valid_i, addr_i, instr_i, pc_add4_i (lane 0 in LSBs)
//           downstream valid_o/ready_i, lane_valid_o, addr_o, instr_o, pc_add4_o, occupancy_o
// Option  : define PIPE_STAGE_SKID_PERF_EN to add stall_cnt_o / bubble_cnt_o saturating counters.
module pipe_stage_skid_reg #(
  parameter int          XLEN      = 32,
  parameter int          LANES     = 1,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [LANES-1:0]      lane_valid_i,
  input  logic [LANES*XLEN-1:0] addr_i,
  input  logic [LANES*32-1:0]   instr_i,
  input  logic [LANES*XLEN-1:0] pc_add4_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [LANES-1:0]      lane_valid_o,
  output logic [LANES*XLEN-1:0] addr_o,
  output logic [LANES*32-1:0]   instr_o,
  output logic [LANES*XLEN-1:0] pc_add4_o,
  output logic [1:0]            occupancy_o
`ifdef PIPE_STAGE_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      bubble_cnt_o
`endif
);

  typedef struct packed {
    logic [LANES-1:0]      lane_valid;
    logic [LANES*XLEN-1:0] addr;
    logic [LANES*32-1:0]   instr;
    logic [LANES*XLEN-1:0] pc_add4;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_nxt;
  beat_t  main_q, main_nxt;
  beat_t  skid_q, skid_nxt;
  beat_t  in_beat;
  logic   push, pop;

  assign in_beat = '{lane_valid: lane_valid_i, addr: addr_i, instr: instr_i, pc_add4: pc_add4_i};

  // Handshake flags depend only on the state register, never on ready_i/valid_i.
  assign ready_o = (state_q != ST_FULL);
  assign valid_o = (state_q != ST_EMPTY);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_comb begin
    occupancy_o = 2'd0;
    case (state_q)
      ST_ONE:  occupancy_o = 2'd1;
      ST_FULL: occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_nxt  = in_beat;
          state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_nxt = in_beat;
        end else if (push) begin
          // Downstream stalled: park the new beat behind the head.
          skid_nxt  = in_beat;
          state_nxt = ST_FULL;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_nxt  = skid_q;
          state_nxt = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any push/pop in the same cycle, including the beat on the input.
    if (flush_i) begin
      state_nxt = ST_EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_nxt;
      main_q  <= main_nxt;
      skid_q  <= skid_nxt;
    end
  end

  // Empty stage or invalid lane presents a canonical NOP with zeroed pc fields.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic lane_on;
    assign lane_on                     = valid_o & main_q.lane_valid[k];
    assign lane_valid_o[k]             = lane_on;
    assign addr_o[k*XLEN +: XLEN]      = lane_on ? main_q.addr[k*XLEN +: XLEN] : '0;
    assign pc_add4_o[k*XLEN +: XLEN]   = lane_on ? main_q.pc_add4[k*XLEN +: XLEN] : '0;
    assign instr_o[k*32 +: 32]         = lane_on ? main_q.instr[k*32 +: 32] : NOP_INSTR;
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q, bubble_q;

  // Counters survive flush so a flush storm is still visible as stall/bubble time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (valid_o && !ready_i && (stall_q != '1))
        stall_q <= stall_q + CNT_ONE;
      if (!valid_o && ready_i && (bubble_q != '1))
        bubble_q <= bubble_q + CNT_ONE;
    end
  end

  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;
  localparam int          L   = 2;
  localparam int          XL  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [L-1:0]    lv;
    logic [L*XL-1:0] addr;
    logic [L*32-1:0] instr;
    logic [L*XL-1:0] pc4;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic [L-1:0]    lane_valid_i = '0;
  logic [L*XL-1:0] addr_i = '0, pc_add4_i = '0;
  logic [L*32-1:0] instr_i = '0;
  logic            ready_o, valid_o;
  logic [L-1:0]    lane_valid_o;
  logic [L*XL-1:0] addr_o, pc_add4_o;
  logic [L*32-1:0] instr_o;
  logic [1:0]      occupancy_o;
`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [15:0]     stall_cnt_o, bubble_cnt_o;
  logic [15:0]     stall_m = '0, bubble_m = '0;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.XLEN(XL), .LANES(L), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .lane_valid_i(lane_valid_i),
    .addr_i(addr_i), .instr_i(instr_i), .pc_add4_i(pc_add4_i),
    .valid_o(valid_o), .ready_i(ready_i), .lane_valid_o(lane_valid_o),
    .addr_o(addr_o), .instr_o(instr_o), .pc_add4_o(pc_add4_o),
    .occupancy_o(occupancy_o)
`ifdef PIPE_STAGE_SKID_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  // Reference model: the stage is a FIFO of at most two beats, exposing the head.
  beat_t exp_q[$];
  bit    pend_vld = 1'b0;
  beat_t pend_beat = '0;
  bit    chk_en = 1'b0;
  int    n_chk = 0, n_fail = 0;

  function automatic beat_t mask_beat(beat_t b);
    beat_t m = b;
    for (int k = 0; k < L; k++) begin
      if (!b.lv[k]) begin
        m.addr[k*XL +: XL]  = '0;
        m.pc4[k*XL +: XL]   = '0;
        m.instr[k*32 +: 32] = NOP;
      end
    end
    return m;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model update on the clock edge, using the inputs that the DUT samples there.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_i) begin
        exp_q.delete();
`ifdef PIPE_STAGE_SKID_PERF_EN
        stall_m  = '0;
        bubble_m = '0;
`endif
        chk_en = 1'b1;
      end else begin
`ifdef PIPE_STAGE_SKID_PERF_EN
        if (exp_q.size() != 0 && !ready_i && stall_m != 16'hFFFF) stall_m++;
        if (exp_q.size() == 0 && ready_i && bubble_m != 16'hFFFF) bubble_m++;
`endif
        if (flush_i) begin
          exp_q.delete();
        end else begin
          if (exp_q.size() != 0 && ready_i) void'(exp_q.pop_front());
          if (pend_vld) exp_q.push_back(pend_beat);
        end
      end
    end
  end

  // Monitor: compares the presented head beat and flags against the model.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = (exp_q.size() != 0) ? exp_q[0] : mask_beat('0);
        check("valid_o", valid_o, exp_q.size() != 0);
        check("ready_o", ready_o, exp_q.size() < 2);
        check("occupancy_o", occupancy_o, exp_q.size());
        check("lane_valid_o", lane_valid_o, (exp_q.size() != 0) ? e.lv : '0);
        check("addr_o", addr_o, e.addr);
        check("instr_o", instr_o, e.instr);
        check("pc_add4_o", pc_add4_o, e.pc4);
`ifdef PIPE_STAGE_SKID_PERF_EN
        check("stall_cnt_o", stall_cnt_o, stall_m);
        check("bubble_cnt_o", bubble_cnt_o, bubble_m);
`endif
      end
    end
  end

  // Drive one cycle of stimulus; the accept decision comes from the model occupancy.
  task automatic cyc(input bit v, input logic [L-1:0] lv, input logic [31:0] pc0,
                     input logic [63:0] ins, input bit rdy, input bit fl, input bit rs);
    @(posedge clk);
    #1;
    valid_i      = v;
    lane_valid_i = lv;
    addr_i       = {pc0 + 32'd4, pc0};
    instr_i      = ins;
    pc_add4_i    = {pc0 + 32'd8, pc0 + 32'd4};
    ready_i      = rdy;
    flush_i      = fl;
    rst_i        = rs;
    pend_vld     = v && !fl && !rs && (exp_q.size() < 2);
    pend_beat    = mask_beat('{lv: lv, addr: addr_i, instr: instr_i, pc4: pc_add4_i});
  endtask

  localparam logic [63:0] INS = {32'h0010_0113, 32'h0000_0093};

  initial begin
    // Reset, then idle with ready high.
    cyc(0, 2'b00, 0, 0, 0, 0, 1);
    cyc(0, 2'b00, 0, 0, 0, 0, 1);
    repeat (3) cyc(0, 2'b00, 0, 0, 1, 0, 0);
    // Back-to-back stream with ready held high.
    cyc(1, 2'b11, 32'h0, INS, 1, 0, 0);
    cyc(1, 2'b11, 32'h4, INS, 1, 0, 0);
    cyc(1, 2'b11, 32'h8, INS, 1, 0, 0);
    cyc(0, 2'b00, 0, 0, 1, 0, 0);
    cyc(0, 2'b00, 0, 0, 1, 0, 0);
    // Fill to FULL, keep offering a third beat, then drain.
    cyc(1, 2'b11, 32'h10, INS, 0, 0, 0);
    cyc(1, 2'b11, 32'h14, INS, 0, 0, 0);
    cyc(1, 2'b11, 32'h18, INS, 0, 0, 0);
    cyc(1, 2'b11, 32'h18, INS, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 1, 0, 0);
    repeat (3) cyc(0, 2'b00, 0, 0, 1, 0, 0);
    // FULL then flush while a new beat is offered.
    cyc(1, 2'b11, 32'h20, INS, 0, 0, 0);
    cyc(1, 2'b11, 32'h24, INS, 0, 0, 0);
    cyc(1, 2'b11, 32'h28, INS, 0, 1, 0);
    repeat (2) cyc(0, 2'b00, 0, 0, 1, 0, 0);
    // Partial and empty lane masks.
    cyc(1, 2'b01, 32'h40, {32'hDEAD_BEEF, 32'h0050_0093}, 1, 0, 0);
    cyc(1, 2'b10, 32'h48, {32'h0020_0193, 32'hCAFE_F00D}, 1, 0, 0);
    cyc(1, 2'b00, 32'h50, {32'h1111_1111, 32'h2222_2222}, 1, 0, 0);
    cyc(0, 2'b00, 0, 0, 1, 0, 0);
    // Stall five cycles with a beat held, flush, then reset.
    cyc(1, 2'b11, 32'h60, INS, 0, 0, 0);
    repeat (4) cyc(0, 2'b00, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 1, 0);
    repeat (2) cyc(0, 2'b00, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 1);
    repeat (2) cyc(0, 2'b00, 0, 0, 1, 0, 0);
    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0, 2'($urandom), $urandom & 32'hFFFF_FFFC,
          {$urandom, $urandom}, ($urandom % 3) != 0,
          ($urandom % 25) == 0, ($urandom % 60) == 0);
    end
    repeat (4) cyc(0, 2'b00, 0, 0, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
